// File: rtl/alu_result_serializer.sv
// Result buffer between the ALU and a 32-bit downstream stream.
// Add results leave as one word; multiply results leave as two (low word, then high word).

module alu_result_serializer #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sel,
    input  logic [63:0]            in_result,
    input  logic                   in_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   out_last,
    output logic                   out_carry,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        BEAT_LOW  = 1'b0,
        BEAT_HIGH = 1'b1
    } beat_t;

    logic [63:0]   entry_result [DEPTH];
    logic          entry_sel    [DEPTH];
    logic          entry_carry  [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    beat_t         beat;

    logic          push;
    logic          beat_xfer;
    logic          last_xfer;
    logic [63:0]   head_result;
    logic          head_sel;
    logic          head_carry;

    // in_ready looks only at the registered count, so out_ready never reaches it.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign beat_xfer = out_valid && out_ready;
    assign last_xfer = beat_xfer && out_last;

    assign head_result = entry_result[rd_ptr];
    assign head_sel    = entry_sel[rd_ptr];
    assign head_carry  = entry_carry[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            entry_result[wr_ptr] <= in_result;
            entry_sel[wr_ptr]    <= in_sel;
            entry_carry[wr_ptr]  <= in_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            beat   <= BEAT_LOW;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (last_xfer) begin
                rd_ptr <= rd_ptr + 1'b1;
                beat   <= BEAT_LOW;
            end else if (beat_xfer) begin
                beat   <= BEAT_HIGH;
            end

            // A push paired with a last-beat pop leaves the occupancy unchanged.
            if (push && !last_xfer) begin
                count <= count + 1'b1;
            end else if (!push && last_xfer) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        out_data  = '0;
        out_last  = 1'b0;
        out_carry = 1'b0;
        if (out_valid) begin
            if (head_sel && (beat == BEAT_LOW)) begin
                out_data = head_result[31:0];
            end else if (head_sel) begin
                out_data  = head_result[63:32];
                out_last  = 1'b1;
                out_carry = head_carry;
            end else begin
                out_data  = head_result[31:0];
                out_last  = 1'b1;
                out_carry = head_carry;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed steps plus random traffic,
// scored against a word-level queue model of the expected output stream.

module tb_alu_result_serializer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [63:0] in_result;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_carry;
    logic [$clog2(DEPTH):0] count;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        carry;
    } word_t;

    word_t exp_q[$];
    int    exp_results = 0;
    bit    last_accepted = 1'b0;
    int    errors = 0;
    int    checks = 0;

    alu_result_serializer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_result (in_result),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_carry (out_carry),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compares the DUT against the model before the edge, then advances both by one clock.
    task automatic cycle();
        bit    push;
        bit    pop;
        word_t w;
        checkOutput("out_valid", out_valid, exp_q.size() != 0);
        checkOutput("in_ready", in_ready, exp_results < DEPTH);
        checkOutput("count", count, 64'(exp_results));
        checkOutput("count_bound", count <= DEPTH, 1);
        if (exp_q.size() != 0) begin
            w = exp_q[0];
            checkOutput("out_data", out_data, w.data);
            checkOutput("out_last", out_last, w.last);
            checkOutput("out_carry", out_carry, w.carry);
        end else begin
            checkOutput("idle_data", out_data, 0);
            checkOutput("idle_last", out_last, 0);
            checkOutput("idle_carry", out_carry, 0);
        end
        push = rst_n && in_valid && (exp_results < DEPTH);
        pop  = rst_n && (exp_q.size() != 0) && out_ready;
        last_accepted = push;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            exp_results = 0;
        end else begin
            if (pop) begin
                w = exp_q.pop_front();
                if (w.last) exp_results--;
            end
            if (push) begin
                if (in_sel) begin
                    exp_q.push_back('{data: in_result[31:0], last: 1'b0, carry: 1'b0});
                    exp_q.push_back('{data: in_result[63:32], last: 1'b1, carry: in_carry});
                end else begin
                    exp_q.push_back('{data: in_result[31:0], last: 1'b1, carry: in_carry});
                end
                exp_results++;
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [63:0] r, input logic c, input logic rdy);
        in_valid  = v;
        in_sel    = s;
        in_result = r;
        in_carry  = c;
        out_ready = rdy;
        cycle();
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
            applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        end
        checkOutput("drain_empty", out_valid, 0);
        checkOutput("drain_count", count, 0);
    endtask

    initial begin
        bit acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 1'b0;
        in_result = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_carry", out_carry, 0);
        rst_n = 1'b1;

        $display("[TB] single add");
        applyStimulus(1'b1, 1'b0, 64'h0000_0000_4049_0FDB, 1'b1, 1'b1);
        checkOutput("add_data", out_data, 32'h4049_0FDB);
        checkOutput("add_last", out_last, 1);
        checkOutput("add_carry", out_carry, 1);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("add_done_valid", out_valid, 0);
        checkOutput("add_done_count", count, 0);

        $display("[TB] single multiply");
        applyStimulus(1'b1, 1'b1, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b1);
        checkOutput("mul_b0_data", out_data, 32'hFFFF_FFFE);
        checkOutput("mul_b0_last", out_last, 0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("mul_b1_data", out_data, 32'h0000_0001);
        checkOutput("mul_b1_last", out_last, 1);
        checkOutput("mul_b1_carry", out_carry, 0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("mul_done_valid", out_valid, 0);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_data", out_data, 32'h9ABC_DEF0);
            checkOutput("bp_hold_last", out_last, 0);
            applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        end
        checkOutput("bp_b0_data", out_data, 32'h9ABC_DEF0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("bp_b1_data", out_data, 32'h1234_5678);
        checkOutput("bp_b1_last", out_last, 1);
        checkOutput("bp_b1_carry", out_carry, 1);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("bp_done_valid", out_valid, 0);

        $display("[TB] full, wrap-around, simultaneous push/pop");
        applyStimulus(1'b1, 1'b0, 64'hAAAA_AAAA_1111_1111, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 64'h2222_2222_3333_3333, 1'b1, 1'b0);
        checkOutput("full_count", count, 2);
        checkOutput("full_in_ready", in_ready, 0);
        applyStimulus(1'b1, 1'b0, 64'h0000_0000_4444_4444, 1'b0, 1'b0);
        checkOutput("full_reject_count", count, 2);
        checkOutput("full_reject_head", out_data, 32'h1111_1111);
        for (int i = 0; i < 6; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) begin
                applyStimulus(1'b1, 1'(i % 2), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
                acc = last_accepted;
            end
            checkOutput("stream_push_accept", acc, 1);
        end
        drain();

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 1'b1, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0000_0000_9999_AAAA, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("pre_rst_beat1", out_data, 32'h5555_6666);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 64'hFFFF_FFFF_CAFE_F00D, 1'b1, 1'b0);
        checkOutput("post_rst_data", out_data, 32'hCAFE_F00D);
        checkOutput("post_rst_last", out_last, 1);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("post_rst_empty", out_valid, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Buffers results from the 32-bit ALU (floating-point add or 32x32 multiply) and streams them downstream as 32-bit words over a valid/ready handshake. Each captured result carries its operation select: add results leave as one word, multiply results as two words (low, then high). A small FIFO decouples ALU issue from downstream back-pressure so the ALU can keep producing while earlier results drain.

## Interface
- DEPTH, 2, number of buffered results; power of two, at least 2.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream has a result to push.
- in_ready  output  1  buffer can accept; equals !full.
- in_sel  input  1  0 = add result, 1 = multiply result (same encoding as the ALU selector).
- in_result  input  64  ALU result; for add only bits [31:0] are meaningful.
- in_carry  input  1  ALU carry flag.
- out_valid  output  1  a word is presented.
- out_ready  input  1  downstream accepts the word.
- out_data  output  32  current word.
- out_last  output  1  final word of the current result.
- out_carry  output  1  carry of the current result; only non-zero on the last word.
- count  output  $clog2(DEPTH)+1  results currently buffered, including the one being drained.

## Operation
- Storage: DEPTH entries of {sel, result[63:0], carry}, plus write pointer, read pointer, occupancy count, and a 1-bit beat counter for the head entry.
- Push: when in_valid && in_ready, store {in_sel, in_result, in_carry} at the write pointer. Advance the write pointer modulo DEPTH and increment count.
- in_ready depends only on count (!full). There is no combinational path from out_ready to in_ready. When full, a same-cycle pop does not enable a push.
- Output: out_valid = (count != 0). Head entry fields:
  - sel=0: one beat. out_data=result[31:0], out_last=1, out_carry=carry. Bits [63:32] are ignored.
  - sel=1, beat 0: out_data=result[31:0], out_last=0, out_carry=0.
  - sel=1, beat 1: out_data=result[63:32], out_last=1, out_carry=carry.
- Beat transfer: out_valid && out_ready.
  - Not last: beat goes 0→1.
  - Last: beat returns to 0, the read pointer advances modulo DEPTH, and count decrements.
- Simultaneous push and last-beat pop: count is unchanged and both pointers advance.
- When out_valid=0, out_data, out_last and out_carry are driven to 0.
- Stability: while out_valid && !out_ready, out_data, out_last and out_carry hold. A push never alters the head entry.
- Pointers wrap from DEPTH-1 to 0 with no gap or duplication.

## Timing
- Reset (rst_n low at a rising edge):
  - pointers, count and beat go to 0.
  - in_ready=1, out_valid=0, out_data=0, out_last=0, out_carry=0.
  - Applies mid-stream: all buffered results and any partially sent multiply are discarded. Beat restarts at 0 for the next result.
- Latency: a push at edge k into an empty buffer gives out_valid=1 with beat 0 after edge k (cycle k+1). There is no same-cycle bypass.
- Throughput:
  - One word per cycle with continuous out_ready.
  - An add result occupies one output cycle; a multiply result occupies two.
- Full: count=DEPTH gives in_ready=0 from the cycle after the filling push. in_ready returns to 1 the cycle after the last-beat pop.
- Empty: out_valid drops the cycle after the final last-beat pop, unless a push occurred on that same edge.

## Test plan
- Single add:
  - Stimulus: push sel=0, result=0x0000_0000_4049_0FDB, carry=1; out_ready=1.
  - Required: one beat next cycle with out_data=0x4049_0FDB, out_last=1, out_carry=1; then out_valid=0 and count=0.
- Single multiply:
  - Stimulus: push sel=1, result=0x0000_0001_FFFF_FFFE, carry=0.
  - Required: beat 0 gives 0xFFFF_FFFE with last=0; beat 1 gives 0x0000_0001 with last=1, out_carry=0.
- Back-pressure:
  - Stimulus: multiply 0x1234_5678_9ABC_DEF0 with out_ready=0 for 5 cycles.
  - Required: out_data holds 0x9ABC_DEF0 and out_last holds 0. After out_ready rises: 0x9ABC_DEF0, then 0x1234_5678.
- Full, wrap-around and simultaneous push/pop (DEPTH=2):
  - Stimulus: push 2 results with out_ready=0.
  - Required: count=2 and in_ready=0; a third in_valid is not accepted.
  - Continue by streaming 6 alternating add/mul results with random out_ready.
  - Required: words come out in order with no loss, and count never exceeds 2.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 for one edge after beat 0 of a multiply, with 1 more result queued.
  - Required: out_valid=0, count=0, in_ready=1.
  - Follow-up: a new add after reset emits a single beat with out_last=1.
